// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run/read sequencer handing memory ownership between host and processor
// Reads are throttled so the 2-entry result FIFO can never overflow.
module run_ctrl #(
  parameter int  PE_ELEMENTS = 4,
  parameter int  DMEM_DEPTH  = 1024,
  parameter int  DATA_LEN    = 32,
  parameter int  CNT_W       = 24,
  parameter int  TIMEOUT     = 65536,
  localparam int AW          = $clog2(DMEM_DEPTH / PE_ELEMENTS)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_op,
  input  logic [AW:0]                     cmd_len,
  input  logic                            abort,
  output logic                            host_own,
  output logic                            proc_start,
  input  logic                            proc_stop,
  output logic                            res_rd_en,
  output logic [AW-1:0]                   res_rd_addr,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] res_rd_dout,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PE_ELEMENTS*DATA_LEN-1:0] out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic [CNT_W-1:0]                run_cycles
);
  localparam int               DW       = PE_ELEMENTS * DATA_LEN;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, READ} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] run_cycles_q;
  logic             timeout_q;
  logic             done_q;
  logic [AW:0]      len_q;
  logic [AW:0]      rd_addr_q;
  logic [AW:0]      out_left_q;
  logic             inflight_q;
  logic [DW-1:0]    fifo_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic [1:0]       occ_after;
  logic             pop;
  logic             push;
  logic             issue;

  // Occupancy is taken after this cycle's pop so a full-rate stream keeps one read per cycle.
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;
  assign occ_after = count_q - {1'b0, pop};
  assign issue     = (state_q == READ) && (rd_addr_q != len_q)
                     && ((occ_after + {1'b0, inflight_q}) < 2'd2);
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

  assign cmd_ready   = (state_q == IDLE);
  assign host_own    = (state_q == IDLE) || (state_q == READ);
  assign proc_start  = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign res_rd_en   = issue;
  assign res_rd_addr = rd_addr_q[AW-1:0];
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = fifo_q[rd_ptr_q];
  assign out_last    = out_valid && (out_left_q == (AW+1)'(1));
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign run_cycles  = run_cycles_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      len_q        <= '0;
      rd_addr_q    <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) rd_addr_q <= rd_addr_q + (AW+1)'(1);
      if (push) begin
        fifo_q[wr_ptr_q] <= res_rd_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        out_left_q <= out_left_q - (AW+1)'(1);
      end

      if (abort) begin
        state_q    <= IDLE;
        inflight_q <= 1'b0;
        count_q    <= 2'd0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        rd_addr_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_valid) begin
              if (!cmd_op) begin
                state_q   <= START;
                cnt_q     <= '0;
                timeout_q <= 1'b0;
              end else if (cmd_len != '0) begin
                state_q    <= READ;
                len_q      <= cmd_len;
                out_left_q <= cmd_len;
                rd_addr_q  <= '0;
                timeout_q  <= 1'b0;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          START: state_q <= RUN;
          RUN: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (proc_stop) begin
              state_q      <= IDLE;
              done_q       <= 1'b1;
              run_cycles_q <= cnt_q + CNT_W'(1);
            end else if (cnt_q == LIMIT_M1) begin
              state_q      <= IDLE;
              timeout_q    <= 1'b1;
              run_cycles_q <= cnt_q + CNT_W'(1);
            end
          end
          READ: begin
            if (pop && out_last) begin
              state_q   <= IDLE;
              done_q    <= 1'b1;
              rd_addr_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed self-checking bench for run_ctrl
module tb_run_ctrl;
  localparam int PE = 4;
  localparam int DL = 32;
  localparam int DW = PE * DL;
  localparam int AW = 8;
  localparam int CW = 24;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_op = 1'b0;
  logic [AW:0]   cmd_len = '0;
  logic          abort = 1'b0;
  logic          proc_stop = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] res_rd_dout = '0;
  logic          cmd_ready, host_own, proc_start, res_rd_en;
  logic          out_valid, out_last, busy, done, timeout;
  logic [AW-1:0] res_rd_addr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] run_cycles;

  int assertions = 0;
  int failures   = 0;

  run_ctrl #(
    .PE_ELEMENTS(PE), .DMEM_DEPTH(1024), .DATA_LEN(DL), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .abort(abort), .host_own(host_own),
    .proc_start(proc_start), .proc_stop(proc_stop), .res_rd_en(res_rd_en),
    .res_rd_addr(res_rd_addr), .res_rd_dout(res_rd_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Result memory: word at address a holds 0xA0 + a, one cycle read latency.
  always @(posedge clk) if (res_rd_en) res_rd_dout <= DW'(32'hA0 + 32'(res_rd_addr));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    assertions++;
    if ({cmd_ready, host_own} !== 2'b11) begin
      failures++; $display("FAIL reset_ready_own: got %b expected 11", {cmd_ready, host_own});
    end
    assertions++;
    if ({proc_start, res_rd_en, out_valid, out_last, busy, done, timeout} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {proc_start, res_rd_en, out_valid, out_last, busy, done, timeout});
    end
    assertions++;
    if (res_rd_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h expected 0", res_rd_addr); end
    assertions++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_data: got %h expected 0", out_data); end
    assertions++;
    if (run_cycles !== '0) begin failures++; $display("FAIL reset_run_cycles: got %0d expected 0", run_cycles); end
  endtask

  task automatic test_run();
    int starts = 0, own0 = 0, dones = 0, first_start = -1;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    @(negedge clk);
    assertions++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL run_accept: got %b expected 1", cmd_ready); end
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      proc_stop = (c == 11);
      @(negedge clk);
      if (proc_start) begin starts++; if (first_start < 0) first_start = c; end
      if (!host_own) own0++;
      if (done) dones++;
      if (c == 12) begin
        assertions++;
        if (done !== 1'b1) begin failures++; $display("FAIL run_done_cycle: got %b expected 1", done); end
      end
      next_cycle();
    end
    proc_stop = 1'b0;
    assertions++;
    if (starts != 1 || first_start != 1) begin
      failures++; $display("FAIL run_start_pulse: got %0d pulses at %0d expected 1 at 1", starts, first_start);
    end
    assertions++;
    if (own0 != 11) begin failures++; $display("FAIL run_host_own: got %0d expected 11", own0); end
    assertions++;
    if (dones != 1) begin failures++; $display("FAIL run_done_count: got %0d expected 1", dones); end
    assertions++;
    if (run_cycles !== CW'(10)) begin failures++; $display("FAIL run_cycles: got %0d expected 10", run_cycles); end
  endtask

  task automatic test_read4();
    logic          exp_v;
    logic [DW-1:0] exp_d;
    out_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 9'd4;
    @(negedge clk);
    assertions++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL read4_accept: got %b expected 1", cmd_ready); end
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_v = (c >= 3 && c <= 6);
      assertions++;
      if (out_valid !== exp_v) begin
        failures++; $display("FAIL read4_valid c%0d: got %b expected %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        exp_d = DW'(32'hA0 + 32'(c - 3));
        assertions++;
        if (out_data !== exp_d) begin
          failures++; $display("FAIL read4_data c%0d: got %h expected %h", c, out_data, exp_d);
        end
        assertions++;
        if (out_last !== (c == 6)) begin
          failures++; $display("FAIL read4_last c%0d: got %b expected %b", c, out_last, (c == 6));
        end
      end
      assertions++;
      if (done !== (c == 7)) begin
        failures++; $display("FAIL read4_done c%0d: got %b expected %b", c, done, (c == 7));
      end
      next_cycle();
    end
  endtask

  task automatic test_read_stall();
    int            got[$];
    int            issued = 0, popped = 0, dones = 0;
    logic          pstall = 1'b0, plast = 1'b0;
    logic [DW-1:0] pdata = '0;
    out_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 9'd3;
    @(negedge clk);
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      out_ready = 1'(c % 2);
      @(negedge clk);
      if (pstall) begin
        assertions++;
        if (out_valid !== 1'b1 || out_data !== pdata || out_last !== plast) begin
          failures++;
          $display("FAIL stall_hold c%0d: got v%b %h l%b expected v1 %h l%b", c, out_valid, out_data, out_last, pdata, plast);
        end
      end
      if (res_rd_en) issued++;
      if (out_valid && out_ready) begin
        popped++;
        got.push_back(int'(out_data[31:0]));
        assertions++;
        if (out_last !== (popped == 3)) begin
          failures++; $display("FAIL stall_last word%0d: got %b expected %b", popped, out_last, (popped == 3));
        end
      end
      assertions++;
      if (issued - popped > 2) begin
        failures++; $display("FAIL stall_outstanding c%0d: got %0d expected <=2", c, issued - popped);
      end
      if (done) dones++;
      pstall = out_valid && !out_ready;
      pdata  = out_data;
      plast  = out_last;
      next_cycle();
    end
    out_ready = 1'b0;
    assertions++;
    if (got.size() != 3) begin failures++; $display("FAIL stall_word_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      assertions++;
      if (got[i] != 32'hA0 + i) begin
        failures++; $display("FAIL stall_word%0d: got %h expected %h", i, got[i], 32'hA0 + i);
      end
    end
    assertions++;
    if (issued != 3) begin failures++; $display("FAIL stall_issued: got %0d expected 3", issued); end
    assertions++;
    if (dones != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL stall_done: got %0d pulses busy %b expected 1 pulse busy 0", dones, busy);
    end
  endtask

  task automatic test_abort();
    int dones = 0, vld = 0, bsy = 0;
    out_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 9'd4;
    @(negedge clk);
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      abort = (c == 4);
      @(negedge clk);
      if (c == 3) begin
        assertions++;
        if (out_valid !== 1'b1 || out_data !== DW'(32'hA0)) begin
          failures++; $display("FAIL abort_first_word: got v%b %h expected v1 a0", out_valid, out_data);
        end
      end
      if (c >= 4 && done) dones++;
      if (c >= 5 && out_valid) vld++;
      if (c >= 5 && busy) bsy++;
      next_cycle();
    end
    abort = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    @(negedge clk);
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      abort = (c == 5); proc_stop = (c == 5);
      @(negedge clk);
      if (c >= 5 && done) dones++;
      if (c >= 6 && (out_valid || busy)) bsy++;
      next_cycle();
    end
    abort = 1'b0; proc_stop = 1'b0;
    assertions++;
    if (dones != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    assertions++;
    if (vld != 0) begin failures++; $display("FAIL abort_flush: got %0d valid cycles expected 0", vld); end
    assertions++;
    if (bsy != 0) begin failures++; $display("FAIL abort_idle: got %0d busy cycles expected 0", bsy); end
    assertions++;
    if (run_cycles !== CW'(10)) begin failures++; $display("FAIL abort_run_cycles: got %0d expected 10", run_cycles); end
  endtask

  task automatic test_timeout();
    int dones = 0;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    @(negedge clk);
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c == 17) begin
        assertions++;
        if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy16: got %b expected 1", busy); end
      end
      if (c == 18) begin
        assertions++;
        if (busy !== 1'b0 || timeout !== 1'b1) begin
          failures++; $display("FAIL timeout_flag: got busy %b timeout %b expected 0 1", busy, timeout);
        end
      end
      next_cycle();
    end
    assertions++;
    if (dones != 0) begin failures++; $display("FAIL timeout_no_done: got %0d expected 0", dones); end
    cmd_valid = 1'b1; cmd_op = 1'b0;
    @(negedge clk);
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      proc_stop = (c == 3);
      @(negedge clk);
      if (c == 1) begin
        assertions++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
      end
      if (c == 4) begin
        assertions++;
        if (done !== 1'b1 || run_cycles !== CW'(2)) begin
          failures++; $display("FAIL timeout_rerun: got done %b cycles %0d expected 1 2", done, run_cycles);
        end
      end
      next_cycle();
    end
    proc_stop = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int vld = 0;
    out_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 9'd4;
    @(negedge clk);
    next_cycle();
    cmd_valid = 1'b0;
    repeat (3) next_cycle();
    rstn = 1'b0;
    #1;
    assertions++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || res_rd_en !== 1'b0) begin
      failures++; $display("FAIL midreset_immediate: got busy %b valid %b rd_en %b expected 0 0 0", busy, out_valid, res_rd_en);
    end
    test_reset();
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 9'd0;
    @(negedge clk);
    assertions++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL len0_accept: got ready %b done %b expected 1 0", cmd_ready, done);
    end
    next_cycle();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (out_valid) vld++;
      assertions++;
      if (done !== (c == 1) || busy !== 1'b0) begin
        failures++; $display("FAIL len0_done c%0d: got done %b busy %b expected %b 0", c, done, busy, (c == 1));
      end
      next_cycle();
    end
    assertions++;
    if (vld != 0) begin failures++; $display("FAIL len0_no_stream: got %0d valid cycles expected 0", vld); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    test_run();
    test_read4();
    test_read_stall();
    test_abort();
    test_timeout();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
